ethernet_udp_receive: RTL

- MII receive counterpart of the UDP transmitter.
- Samples PHY rx nibbles in the system clock domain and validates the frame: Ethernet II, then IPv4, then UDP.
- Extracts a fixed-size UDP payload of DATA_BYTES and presents it with a one-cycle valid pulse plus sender addressing.
- Sits between the EthernetPHY rx pins and user logic.

---
 rtl/ethernet_pkg.sv | 35 +++
 rtl/mii_rx_sampler.sv | 80 ++++++++
 rtl/ethernet_udp_receive.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ethernet_pkg.sv
// Shared constants, receive FSM states and the reflected CRC-32 step used by the MII UDP receiver.
package ethernet_pkg;

  localparam logic [3:0]  ETH_PRE_NIBBLE    = 4'h5;
  localparam logic [3:0]  ETH_SFD_NIBBLE    = 4'hD;
  localparam logic [15:0] ETH_TYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL        = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP      = 8'h11;
  localparam int unsigned UDP_HDR_BYTES     = 8;
  localparam int unsigned HDR_BYTES         = 42;
  localparam logic [31:0] CRC32_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE     = 32'hDEBB20E3;
  localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    TRAILER,
    DROP
  } rx_state_t;

  // One byte of the LSB-first CRC-32, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_sampler.sv
// Synchronises the MII rx pins into clk, detects rx_clk rising edges (ticks) and assembles bytes.
module mii_rx_sampler
  import ethernet_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_clk,
  input  logic       rx_dv,
  input  logic       rx_er,
  input  logic [3:0] rx_d,
  input  logic       hunt,
  output logic       tick,
  output logic       dv,
  output logic [3:0] nibble,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       rx_err,
  output logic       odd_nibble
);

  logic [6:0] sync1, sync2;
  logic       clk_prev;
  logic [3:0] low_nib;
  logic       s_clk, s_dv, s_er, tick_c;
  logic [3:0] s_d;

  assign {s_clk, s_dv, s_er, s_d} = sync2;
  assign tick_c = s_clk & ~clk_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      clk_prev <= 1'b0;
    end else begin
      sync1    <= {rx_clk, rx_dv, rx_er, rx_d};
      sync2    <= sync1;
      clk_prev <= s_clk;
    end
  end

  // Nibble pairing restarts whenever the receiver is not inside a frame body.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick        <= 1'b0;
      dv          <= 1'b0;
      nibble      <= '0;
      data_byte   <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      rx_err      <= 1'b0;
      odd_nibble  <= 1'b0;
      low_nib     <= '0;
    end else begin
      tick        <= tick_c;
      dv          <= s_dv;
      nibble      <= s_d;
      frame_start <= tick_c & s_dv & (s_d == ETH_SFD_NIBBLE);
      frame_end   <= tick_c & ~s_dv;
      rx_err      <= tick_c & s_er;
      byte_valid  <= 1'b0;
      if (hunt) begin
        odd_nibble <= 1'b0;
      end else if (tick_c && s_dv) begin
        if (odd_nibble) begin
          data_byte  <= {s_d, low_nib};
          byte_valid <= 1'b1;
          odd_nibble <= 1'b0;
        end else begin
          low_nib    <= s_d;
          odd_nibble <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ethernet_udp_receive.sv
// MII Ethernet/IPv4/UDP receiver delivering a fixed-size payload with a one-clk valid pulse.
// Define ETH_UDP_RX_FCS_CHECK_EN to verify the Ethernet FCS before accepting a frame.
module ethernet_udp_receive
  import ethernet_pkg::*;
#(
  parameter int unsigned DATA_BYTES        = 16,
  parameter int unsigned MIN_CLK_PER_RXCLK = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    eth_rx_clk,
  input  logic                    eth_rx_dv,
  input  logic                    eth_rx_er,
  input  logic [3:0]              eth_rx_d,
  input  logic [47:0]             local_mac,
  input  logic [31:0]             local_ip,
  input  logic [15:0]             local_port,
  output logic [8*DATA_BYTES-1:0] data,
  output logic [47:0]             src_mac,
  output logic [31:0]             src_ip,
  output logic [15:0]             src_port,
  output logic                    valid,
  output logic [15:0]             drop_count
);

  localparam int unsigned IDX_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [15:0] UDP_LEN  = 16'(UDP_HDR_BYTES + DATA_BYTES);
  localparam logic [7:0]  LAST_HDR = 8'(HDR_BYTES - 1);
  localparam logic [7:0]  LAST_PAY = 8'(DATA_BYTES - 1);

  if (MIN_CLK_PER_RXCLK < 4) begin : g_bad_ratio
    $error("ethernet_udp_receive needs at least 4 clk cycles per eth_rx_clk period");
  end
  if (DATA_BYTES < 1 || DATA_BYTES > 256) begin : g_bad_size
    $error("ethernet_udp_receive supports 1 to 256 payload bytes");
  end

  rx_state_t  state, state_n;
  logic       tick, dv, byte_valid, frame_start, frame_end, rx_err, odd_nibble, hunt;
  logic [3:0] nibble;
  logic [7:0] data_byte;

  logic [7:0]  cnt;
  logic [2:0]  trail_cnt;
  logic        lmac_ok, bmac_ok;
  logic [47:0] mac_sh;
  logic [31:0] ip_sh;
  logic [15:0] port_sh;
  logic [7:0]  shadow [DATA_BYTES];

  logic [7:0] exp_c;
  logic       mac_c, chk_c, l_ok_c, b_ok_c, hdr_ok_c, crc_bad_c;
  logic       cnt_clr_c, cnt_inc_c, drop_c, accept_c;

  assign hunt = !(state == HEADER || state == PAYLOAD || state == TRAILER);

  mii_rx_sampler u_sampler (
    .clk         (clk),
    .reset       (reset),
    .rx_clk      (eth_rx_clk),
    .rx_dv       (eth_rx_dv),
    .rx_er       (eth_rx_er),
    .rx_d        (eth_rx_d),
    .hunt        (hunt),
    .tick        (tick),
    .dv          (dv),
    .nibble      (nibble),
    .data_byte   (data_byte),
    .byte_valid  (byte_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .rx_err      (rx_err),
    .odd_nibble  (odd_nibble)
  );

  // Expected value for each checked header byte; MAC accepts either local or broadcast.
  always_comb begin
    exp_c = 8'h00;
    mac_c = 1'b0;
    chk_c = 1'b0;
    case (cnt)
      8'd0:  begin exp_c = local_mac[47:40]; mac_c = 1'b1; end
      8'd1:  begin exp_c = local_mac[39:32]; mac_c = 1'b1; end
      8'd2:  begin exp_c = local_mac[31:24]; mac_c = 1'b1; end
      8'd3:  begin exp_c = local_mac[23:16]; mac_c = 1'b1; end
      8'd4:  begin exp_c = local_mac[15:8];  mac_c = 1'b1; end
      8'd5:  begin exp_c = local_mac[7:0];   mac_c = 1'b1; end
      8'd12: begin exp_c = ETH_TYPE_IPV4[15:8]; chk_c = 1'b1; end
      8'd13: begin exp_c = ETH_TYPE_IPV4[7:0];  chk_c = 1'b1; end
      8'd14: begin exp_c = IP_VER_IHL;          chk_c = 1'b1; end
      8'd23: begin exp_c = IP_PROTO_UDP;        chk_c = 1'b1; end
      8'd30: begin exp_c = local_ip[31:24];     chk_c = 1'b1; end
      8'd31: begin exp_c = local_ip[23:16];     chk_c = 1'b1; end
      8'd32: begin exp_c = local_ip[15:8];      chk_c = 1'b1; end
      8'd33: begin exp_c = local_ip[7:0];       chk_c = 1'b1; end
      8'd36: begin exp_c = local_port[15:8];    chk_c = 1'b1; end
      8'd37: begin exp_c = local_port[7:0];     chk_c = 1'b1; end
      8'd38: begin exp_c = UDP_LEN[15:8];       chk_c = 1'b1; end
      8'd39: begin exp_c = UDP_LEN[7:0];        chk_c = 1'b1; end
      default: ;
    endcase
    l_ok_c   = lmac_ok & (data_byte == exp_c);
    b_ok_c   = bmac_ok & (data_byte == ETH_BROADCAST_MAC[7:0]);
    hdr_ok_c = mac_c ? (l_ok_c | b_ok_c) : (!chk_c || (data_byte == exp_c));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr_c = 1'b0;
    cnt_inc_c = 1'b0;
    drop_c    = 1'b0;
    accept_c  = 1'b0;
    if (tick) begin
      case (state)
        WAIT_IDLE: if (!dv) state_n = IDLE;
        IDLE:      if (dv) state_n = (nibble == ETH_PRE_NIBBLE) ? PREAMBLE : DROP;
        PREAMBLE: begin
          if (rx_err)                        state_n = DROP;
          else if (!dv)                      state_n = IDLE;
          else if (frame_start)              begin state_n = HEADER; cnt_clr_c = 1'b1; end
          else if (nibble != ETH_PRE_NIBBLE) state_n = DROP;
        end
        HEADER: begin
          if (rx_err)         begin state_n = DROP; drop_c = 1'b1; end
          else if (frame_end) begin state_n = IDLE; drop_c = 1'b1; end
          else if (byte_valid) begin
            if (!hdr_ok_c)             begin state_n = DROP; drop_c = 1'b1; end
            else if (cnt == LAST_HDR)  begin state_n = PAYLOAD; cnt_clr_c = 1'b1; end
            else                       cnt_inc_c = 1'b1;
          end
        end
        PAYLOAD: begin
          if (rx_err)         begin state_n = DROP; drop_c = 1'b1; end
          else if (frame_end) begin state_n = IDLE; drop_c = 1'b1; end
          else if (byte_valid) begin
            if (cnt == LAST_PAY) state_n = TRAILER;
            else                 cnt_inc_c = 1'b1;
          end
        end
        TRAILER: begin
          if (rx_err) begin
            state_n = DROP;
            drop_c  = 1'b1;
          end else if (frame_end) begin
            state_n = IDLE;
            if (odd_nibble || trail_cnt < 3'd4 || crc_bad_c) drop_c   = 1'b1;
            else                                             accept_c = 1'b1;
          end
        end
        DROP:    if (!dv) state_n = IDLE;
        default: state_n = WAIT_IDLE;
      endcase
    end
  end

  // Header bookkeeping: byte counter, MAC match flags and captured sender fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      trail_cnt <= '0;
      lmac_ok   <= 1'b0;
      bmac_ok   <= 1'b0;
      mac_sh    <= '0;
      ip_sh     <= '0;
      port_sh   <= '0;
    end else begin
      if (cnt_clr_c)      cnt <= '0;
      else if (cnt_inc_c) cnt <= cnt + 8'd1;
      if (cnt_clr_c) begin
        lmac_ok <= 1'b1;
        bmac_ok <= 1'b1;
      end else if (byte_valid && state == HEADER) begin
        if (cnt < 8'd6) begin
          lmac_ok <= l_ok_c;
          bmac_ok <= b_ok_c;
        end
        if (cnt >= 8'd6 && cnt <= 8'd11)   mac_sh  <= {mac_sh[39:0], data_byte};
        if (cnt >= 8'd26 && cnt <= 8'd29)  ip_sh   <= {ip_sh[23:0], data_byte};
        if (cnt >= 8'd34 && cnt <= 8'd35)  port_sh <= {port_sh[7:0], data_byte};
      end
      if (state != TRAILER)                           trail_cnt <= '0;
      else if (byte_valid && trail_cnt != 3'd4)       trail_cnt <= trail_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DATA_BYTES; i++) shadow[i] <= '0;
    end else if (byte_valid && state == PAYLOAD) begin
      shadow[IDX_W'(cnt)] <= data_byte;
    end
  end

`ifdef ETH_UDP_RX_FCS_CHECK_EN
  logic [31:0] crc;

  // Runs from the first destination MAC byte through the FCS; good frames leave the residue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   crc <= '1;
    else if (state == PREAMBLE && cnt_clr_c)     crc <= '1;
    else if (byte_valid && !hunt)                crc <= crc32_byte(crc, data_byte);
  end

  assign crc_bad_c = (crc != CRC32_RESIDUE);
`else
  assign crc_bad_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data       <= '0;
      src_mac    <= '0;
      src_ip     <= '0;
      src_port   <= '0;
      valid      <= 1'b0;
      drop_count <= '0;
    end else begin
      valid <= accept_c;
      if (accept_c) begin
        for (int i = 0; i < DATA_BYTES; i++) data[8*i +: 8] <= shadow[i];
        src_mac  <= mac_sh;
        src_ip   <= ip_sh;
        src_port <= port_sh;
      end
      if (drop_c && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule
